// File: rtl/sr_pkg.sv
// ---------------------------------------------------------------------------
// sr_pkg
// Shared definitions for the SR flip-flop library cell.
//   SR_HOLD / SR_SET / SR_RESET / SR_TOGGLE : action taken when s=1 and r=1
//   next_q()                                : next state of one SR bit
// ---------------------------------------------------------------------------
package sr_pkg;

  localparam int SR_HOLD   = 0;
  localparam int SR_SET    = 1;
  localparam int SR_RESET  = 2;
  localparam int SR_TOGGLE = 3;

  // True when mode is one of the four supported s=r=1 actions.
  function automatic bit mode_is_legal(input int mode);
    return (mode >= SR_HOLD) && (mode <= SR_TOGGLE);
  endfunction

  // Next state of a single SR bit; rst is handled by the caller.
  function automatic logic next_q(input logic q, input logic s, input logic r,
                                  input int mode);
    logic nq;
    nq = q;
    unique case ({s, r})
      2'b00: nq = q;
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      2'b11: begin
        case (mode)
          SR_SET:    nq = 1'b1;
          SR_RESET:  nq = 1'b0;
          SR_TOGGLE: nq = ~q;
          default:   nq = q;   // SR_HOLD
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// ---------------------------------------------------------------------------
// sr_cell
// One clocked SR bit with its previous-state register.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (wins over s/r)
//   s, r  : set / clear requests
//   q     : stored state
//   qb    : complement of q, derived from the same register so it can never
//           equal q
//   qprev : value of q before the most recent edge (0 after reset)
// ---------------------------------------------------------------------------
module sr_cell
  import sr_pkg::*;
#(
  parameter int BOTH_MODE = SR_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qb,
  output logic qprev
);

  logic q_reg;
  logic q_next;
  logic qprev_reg;

  always_comb begin
    q_next = next_q(q_reg, s, r, BOTH_MODE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg     <= 1'b0;
      qprev_reg <= 1'b0;
    end else begin
      q_reg     <= q_next;
      qprev_reg <= q_reg;
    end
  end

  assign q     = q_reg;
  assign qb    = ~q_reg;
  assign qprev = qprev_reg;

endmodule

// File: rtl/sr_flip_flop.sv
// ---------------------------------------------------------------------------
// sr_flip_flop
// WIDTH independent clocked SR bits.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, priority over s and r
//   s     : [WIDTH] per-bit set request
//   r     : [WIDTH] per-bit clear request
//   q     : [WIDTH] stored state
//   qb    : [WIDTH] complement of q
//   qprev : [WIDTH] q as it was before the last rising edge
// BOTH_MODE selects the s=r=1 action (SR_HOLD/SR_SET/SR_RESET/SR_TOGGLE).
// ---------------------------------------------------------------------------
module sr_flip_flop
  import sr_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int BOTH_MODE = SR_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] qprev
);

  // Reject bad parameterisations while elaborating rather than building
  // a cell with silently undefined s=r=1 behaviour.
  if (WIDTH < 1) begin : g_bad_width
    $error("sr_flip_flop: WIDTH must be >= 1");
  end
  if (!mode_is_legal(BOTH_MODE)) begin : g_bad_mode
    $error("sr_flip_flop: BOTH_MODE must be SR_HOLD, SR_SET, SR_RESET or SR_TOGGLE");
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      sr_cell #(
        .BOTH_MODE(BOTH_MODE)
      ) u_cell (
        .clk   (clk),
        .rst   (rst),
        .s     (s[gi]),
        .r     (r[gi]),
        .q     (q[gi]),
        .qb    (qb[gi]),
        .qprev (qprev[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sr_flip_flop.sv
// ---------------------------------------------------------------------------
// tb_sr_flip_flop
// Four 4-bit instances, one per BOTH_MODE (index = mode), share clk/rst/s/r.
// Directed steps with hand-computed expectations, then a random run checked
// against a bitwise reference model.
// ---------------------------------------------------------------------------
module tb_sr_flip_flop;
  import sr_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] s;
  logic [W-1:0] r;
  logic [W-1:0] q_o   [4];
  logic [W-1:0] qb_o  [4];
  logic [W-1:0] qp_o  [4];

  int checks;
  int errors;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      sr_flip_flop #(
        .WIDTH     (W),
        .BOTH_MODE (gi)
      ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .s     (s),
        .r     (r),
        .q     (q_o[gi]),
        .qb    (qb_o[gi]),
        .qprev (qp_o[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check q, qb and qprev of one instance.
  task automatic chk_inst(input int m, input string tag,
                          input logic [W-1:0] eq, input logic [W-1:0] eqp);
    chk($sformatf("%s.m%0d.q", tag, m), q_o[m], eq);
    chk($sformatf("%s.m%0d.qb", tag, m), qb_o[m], ~eq);
    chk($sformatf("%s.m%0d.qprev", tag, m), qp_o[m], eqp);
  endtask

  // Expected (q, qprev) per mode: hold, set, reset, toggle.
  task automatic expect4(input string tag,
                         input logic [W-1:0] hq, input logic [W-1:0] hp,
                         input logic [W-1:0] sq, input logic [W-1:0] sp,
                         input logic [W-1:0] rq, input logic [W-1:0] rp,
                         input logic [W-1:0] tq, input logic [W-1:0] tp);
    chk_inst(SR_HOLD,   tag, hq, hp);
    chk_inst(SR_SET,    tag, sq, sp);
    chk_inst(SR_RESET,  tag, rq, rp);
    chk_inst(SR_TOGGLE, tag, tq, tp);
  endtask

  task automatic expect_all(input string tag, input logic [W-1:0] eq, input logic [W-1:0] eqp);
    expect4(tag, eq, eqp, eq, eqp, eq, eqp, eq, eqp);
  endtask

  // Drive inputs, take one rising edge, then settle before sampling.
  task automatic step(input string tag, input logic rst_v,
                      input logic [W-1:0] s_v, input logic [W-1:0] r_v);
    rst = rst_v;
    s   = s_v;
    r   = r_v;
    @(posedge clk);
    #1;
    $display("%-12s rst=%b s=%b r=%b q=%b/%b/%b/%b", tag, rst_v, s_v, r_v,
             q_o[0], q_o[1], q_o[2], q_o[3]);
  endtask

  // Reference model, written in bitwise form independently of the cell.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] q, input logic [W-1:0] sv,
                                              input logic [W-1:0] rv, input int mode);
    logic [W-1:0] base;
    logic [W-1:0] both;
    both = sv & rv;
    base = (q | (sv & ~rv)) & ~(rv & ~sv);
    case (mode)
      1:       return base | both;
      2:       return base & ~both;
      3:       return base ^ both;
      default: return base;
    endcase
  endfunction

  logic [W-1:0] mq  [4];
  logic [W-1:0] mqp [4];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    s   = '0;
    r   = '0;
    @(negedge clk);

    // Reset beats s=r=1.
    step("rst_prio", 1'b1, 4'hF, 4'hF);
    expect_all("rst_prio", 4'h0, 4'h0);

    // Basic sequence, every bit driven the same.
    step("clr1", 1'b0, 4'h0, 4'hF);  expect_all("clr1", 4'h0, 4'h0);
    step("clr2", 1'b0, 4'h0, 4'hF);  expect_all("clr2", 4'h0, 4'h0);
    step("set1", 1'b0, 4'hF, 4'h0);  expect_all("set1", 4'hF, 4'h0);
    step("set2", 1'b0, 4'hF, 4'h0);  expect_all("set2", 4'hF, 4'hF);
    step("hold1", 1'b0, 4'h0, 4'h0); expect_all("hold1", 4'hF, 4'hF);
    step("hold2", 1'b0, 4'h0, 4'h0); expect_all("hold2", 4'hF, 4'hF);

    // s=r=1 starting from q=1; toggle twice returns to 1.
    step("both1a", 1'b0, 4'hF, 4'hF);
    expect4("both1a", 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
    step("both1b", 1'b0, 4'hF, 4'hF);
    expect4("both1b", 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);

    step("hold3", 1'b0, 4'h0, 4'h0);
    expect4("hold3", 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF);
    step("hold4", 1'b0, 4'h0, 4'h0);
    expect4("hold4", 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF);

    step("clr3", 1'b0, 4'h0, 4'hF);
    expect4("clr3", 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
    step("clr4", 1'b0, 4'h0, 4'hF);
    expect_all("clr4", 4'h0, 4'h0);

    // s=r=1 starting from q=0.
    step("both0a", 1'b0, 4'hF, 4'hF);
    expect4("both0a", 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0);
    step("both0b", 1'b0, 4'hF, 4'hF);
    expect4("both0b", 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);

    step("rst_both", 1'b1, 4'hF, 4'hF);
    expect_all("rst_both", 4'h0, 4'h0);

    // Reset in the middle of a held set.
    step("mid_set1", 1'b0, 4'hF, 4'h0); expect_all("mid_set1", 4'hF, 4'h0);
    step("mid_set2", 1'b0, 4'hF, 4'h0); expect_all("mid_set2", 4'hF, 4'hF);
    step("mid_rst", 1'b1, 4'hF, 4'h0);  expect_all("mid_rst", 4'h0, 4'h0);
    step("mid_rel", 1'b0, 4'hF, 4'h0);  expect_all("mid_rel", 4'hF, 4'h0);

    // Bit independence.
    step("vec_rst", 1'b1, 4'h0, 4'h0);      expect_all("vec_rst", 4'h0, 4'h0);
    step("vec1", 1'b0, 4'b1010, 4'b0101);   expect_all("vec1", 4'b1010, 4'b0000);
    step("vec2", 1'b0, 4'b0001, 4'b1000);   expect_all("vec2", 4'b0011, 4'b1010);

    // Random run against the model, all state known at this point.
    for (int m = 0; m < 4; m++) begin
      mq[m]  = 4'b0011;
      mqp[m] = 4'b1010;
    end
    for (int i = 0; i < 200; i++) begin
      logic         rv;
      logic [W-1:0] sv;
      logic [W-1:0] cv;
      rv = ($urandom_range(0, 15) == 0);
      sv = W'($urandom);
      cv = W'($urandom);
      for (int m = 0; m < 4; m++) begin
        if (rv) begin
          mqp[m] = '0;
          mq[m]  = '0;
        end else begin
          mqp[m] = mq[m];
          mq[m]  = model_next(mq[m], sv, cv, m);
        end
      end
      step($sformatf("rnd%0d", i), rv, sv, cv);
      for (int m = 0; m < 4; m++) begin
        chk_inst(m, $sformatf("rnd%0d", i), mq[m], mqp[m]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
